cdb_arbiter: RTL and testbench

Arbitrates the common data bus between the functional units (fxu0, fxu1, lsu, branch) that finish instructions. Each unit presents a completed result as a ROB index and a value. The arbiter grants up to NUM_BUS of them per cycle, round-robin, and drives registered broadcast lanes. Those lanes feed the ROB (cdb_valid/indices/new_values) and every reservation station.

---
 rtl/cdb_pkg.sv | 27 ++
 rtl/rr_pick_n.sv | 40 ++++
 rtl/cdb_arbiter.sv | 120 ++++++++++++
 tb/tb_cdb_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter: default widths,
// functional-unit identifiers and a pointer-width helper.
package cdb_pkg;

  // Default widths for ROB indices and result values.
  localparam int CDB_IDX_W   = 4;
  localparam int CDB_DATA_W  = 16;

  // Default requester / lane counts.
  localparam int CDB_NUM_REQ = 4;
  localparam int CDB_NUM_BUS = 2;

  // Requester slot assignment on the req_* vectors.
  typedef enum logic [1:0] {
    FU_FXU0   = 2'd0,
    FU_FXU1   = 2'd1,
    FU_LSU    = 2'd2,
    FU_BRANCH = 2'd3
  } fu_id_e;

  // Width of a pointer/id that selects one of n requesters; never zero so
  // a single-requester build still has a legal one-bit vector.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : cdb_pkg

// File: rtl/rr_pick_n.sv
// Round-robin pick of up to NUM_BUS requesters per cycle. Scanning starts at
// rr_ptr_i and wraps; the n-th valid requester found is placed on lane n.
// Purely combinational: the caller owns the pointer register.
module rr_pick_n
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int NUM_BUS = CDB_NUM_BUS,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]       valid_i,
  input  logic [PTR_W-1:0]         rr_ptr_i,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [NUM_BUS*PTR_W-1:0] lane_src_o,
  output logic [NUM_BUS-1:0]       lane_valid_o
);

  // Walk the requesters in rotated order, granting the first NUM_BUS valid ones.
  always_comb begin
    int lane;
    int pos;
    // NOTE: every output gets a default before the loop; a path that skipped
    // an assignment would otherwise infer a latch.
    grant_o      = '0;
    lane_src_o   = '0;
    lane_valid_o = '0;
    lane         = 0;
    pos          = 0;
    for (int s = 0; s < NUM_REQ; s++) begin
      pos = (int'(rr_ptr_i) + s) % NUM_REQ;
      if (valid_i[pos] && (lane < NUM_BUS)) begin
        grant_o[pos]                          = 1'b1;
        lane_valid_o[lane]                    = 1'b1;
        lane_src_o[lane*PTR_W +: PTR_W]       = PTR_W'(pos);
        lane                                  = lane + 1;
      end
    end
  end

endmodule : rr_pick_n

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter. Grants up to NUM_BUS completed results per cycle in
// round-robin order and broadcasts them on registered lanes one cycle later.
// The lanes are a single register stage: every cycle overwrites them, so a
// granted result is visible for exactly one cycle.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int NUM_BUS = CDB_NUM_BUS,
  parameter int IDX_W   = CDB_IDX_W,
  parameter int DATA_W  = CDB_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*IDX_W-1:0]  req_idx,
  input  logic [NUM_REQ*DATA_W-1:0] req_value,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_BUS-1:0]        cdb_valid,
  output logic [NUM_BUS*IDX_W-1:0]  cdb_idx,
  output logic [NUM_BUS*DATA_W-1:0] cdb_value,
  output logic [15:0]               conflict_cnt
);

  localparam int PTR_W = ptr_width(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

  // State and next-state.
  logic [PTR_W-1:0]         rr_ptr_q,    rr_ptr_d;
  logic [NUM_BUS-1:0]       cdb_valid_q, cdb_valid_d;
  logic [NUM_BUS*IDX_W-1:0] cdb_idx_q,   cdb_idx_d;
  logic [NUM_BUS*DATA_W-1:0] cdb_value_q, cdb_value_d;
  logic [15:0]              conflict_q,  conflict_d;

  // Picker results.
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_BUS*PTR_W-1:0] lane_src;
  logic [NUM_BUS-1:0]       lane_valid;

  // Grants are only honoured outside reset and flush.
  logic arb_en;
  assign arb_en = rst_n & ~flush;

  rr_pick_n #(
    .NUM_REQ (NUM_REQ),
    .NUM_BUS (NUM_BUS),
    .PTR_W   (PTR_W)
  ) u_pick (
    .valid_i      (req_valid),
    .rr_ptr_i     (rr_ptr_q),
    .grant_o      (grant),
    .lane_src_o   (lane_src),
    .lane_valid_o (lane_valid)
  );

  assign req_ready = arb_en ? grant : '0;

  // Steer granted results onto lanes and advance the pointer past the last grant.
  always_comb begin
    logic [PTR_W-1:0] src;
    logic [PTR_W-1:0] last_src;
    logic             any_grant;
    src         = '0;
    last_src    = '0;
    any_grant   = 1'b0;
    cdb_valid_d = '0;
    // Idle lanes keep their payload; only the valid bit is meaningful there.
    cdb_idx_d   = cdb_idx_q;
    cdb_value_d = cdb_value_q;
    for (int k = 0; k < NUM_BUS; k++) begin
      src = lane_src[k*PTR_W +: PTR_W];
      if (arb_en && lane_valid[k]) begin
        cdb_valid_d[k]                   = 1'b1;
        cdb_idx_d[k*IDX_W +: IDX_W]      = req_idx[int'(src)*IDX_W +: IDX_W];
        cdb_value_d[k*DATA_W +: DATA_W]  = req_value[int'(src)*DATA_W +: DATA_W];
        // Lanes fill in scan order, so the highest filled lane is the last grant.
        last_src                         = src;
        any_grant                        = 1'b1;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      rr_ptr_d = (last_src == LAST_REQ) ? '0 : last_src + 1'b1;
    end
  end

  // Count cycles where more units are ready to complete than there are lanes.
  always_comb begin
    conflict_d = conflict_q;
    if (arb_en && ($countones(req_valid) > NUM_BUS) && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  // Register stage: lanes, round-robin pointer and conflict counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= '0;
      cdb_idx_q   <= '0;
      cdb_value_q <= '0;
      conflict_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_idx_q   <= cdb_idx_d;
      cdb_value_q <= cdb_value_d;
      conflict_q  <= conflict_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_idx      = cdb_idx_q;
  assign cdb_value    = cdb_value_q;
  assign conflict_cnt = conflict_q;

endmodule : cdb_arbiter

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a table of per-cycle stimulus with hand-derived
// grants, lane sources and conflict counts. Expected lane contents are queued
// when a cycle is driven and compared when the lanes update one edge later.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int NR = 4;
  localparam int NB = 2;
  localparam int IW = 4;
  localparam int DW = 16;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic [NR-1:0]     req_valid;
  logic [NR*IW-1:0]  req_idx;
  logic [NR*DW-1:0]  req_value;
  logic [NR-1:0]     req_ready;
  logic [NB-1:0]     cdb_valid;
  logic [NB*IW-1:0]  cdb_idx;
  logic [NB*DW-1:0]  cdb_value;
  logic [15:0]       conflict_cnt;

  cdb_arbiter #(.NUM_REQ(NR), .NUM_BUS(NB), .IDX_W(IW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_idx      (req_idx),
    .req_value    (req_value),
    .req_ready    (req_ready),
    .cdb_valid    (cdb_valid),
    .cdb_idx      (cdb_idx),
    .cdb_value    (cdb_value),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus with its hand-derived expectations.
  typedef struct {
    logic        rst_n;
    logic        flush;
    logic [3:0]  valid;
    logic [3:0]  ready;   // expected req_ready this cycle
    int          src0;    // unit expected on lane0 next cycle, -1 = none
    int          src1;    // unit expected on lane1 next cycle, -1 = none
    logic [15:0] cnt;     // expected conflict_cnt after the edge
    logic        p2_9;    // load unit 2 with idx 9 / value 0999 before driving
  } vec_t;

  // Scoreboard entry: what the lanes must show after the edge.
  typedef struct {
    logic [NB-1:0]    v;
    logic [NB*IW-1:0] idx;
    logic [NB*DW-1:0] val;
    logic [15:0]      cnt;
    logic             zero;   // reset edge: payload must also be zero
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  logic [IW-1:0] pay_idx [NR];
  logic [DW-1:0] pay_val [NR];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the lanes now visible.
  task automatic compare_lanes(input int step);
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check($sformatf("cdb_valid[%0d]", step), 32'(cdb_valid), 32'(e.v));
    check($sformatf("conflict_cnt[%0d]", step), 32'(conflict_cnt), 32'(e.cnt));
    for (int k = 0; k < NB; k++) begin
      if (e.v[k] || e.zero) begin
        check($sformatf("lane%0d_idx[%0d]", k, step),
              32'(cdb_idx[k*IW +: IW]), 32'(e.idx[k*IW +: IW]));
        check($sformatf("lane%0d_val[%0d]", k, step),
              32'(cdb_value[k*DW +: DW]), 32'(e.val[k*DW +: DW]));
      end
    end
  endtask

  task automatic drive_payloads();
    for (int u = 0; u < NR; u++) begin
      req_idx[u*IW +: IW]   = pay_idx[u];
      req_value[u*DW +: DW] = pay_val[u];
    end
  endtask

  initial begin
    vec_t v;
    exp_t e;
    int   srcs[NB];

    //         rst flush valid    ready    s0  s1  cnt    p2_9
    vecs.push_back('{1'b0, 1'b0, 4'b1111, 4'b0000, -1, -1, 16'd0, 1'b0}); // ready held low in reset
    vecs.push_back('{1'b1, 1'b0, 4'b0001, 4'b0001,  0, -1, 16'd0, 1'b0}); // single request
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 4'b0000, -1, -1, 16'd0, 1'b0}); // idle, lanes drop
    vecs.push_back('{1'b1, 1'b0, 4'b1000, 4'b1000,  3, -1, 16'd0, 1'b0}); // ptr 1 -> 0 via unit 3
    vecs.push_back('{1'b1, 1'b0, 4'b1111, 4'b0011,  0,  1, 16'd1, 1'b0}); // all valid from ptr 0
    vecs.push_back('{1'b1, 1'b0, 4'b1111, 4'b1100,  2,  3, 16'd2, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'b0011, 4'b0011,  0,  1, 16'd2, 1'b0}); // only 2 valid: no count
    vecs.push_back('{1'b1, 1'b0, 4'b0100, 4'b0100,  2, -1, 16'd2, 1'b0}); // ptr -> 3
    vecs.push_back('{1'b1, 1'b0, 4'b1001, 4'b1001,  3,  0, 16'd2, 1'b0}); // wrap: 3 lane0, 0 lane1
    vecs.push_back('{1'b1, 1'b0, 4'b1000, 4'b1000,  3, -1, 16'd2, 1'b0}); // ptr 1 -> 0
    vecs.push_back('{1'b1, 1'b0, 4'b0111, 4'b0011,  0,  1, 16'd3, 1'b1}); // unit 2 held off
    vecs.push_back('{1'b1, 1'b0, 4'b0100, 4'b0100,  2, -1, 16'd3, 1'b0}); // held unit granted
    vecs.push_back('{1'b1, 1'b1, 4'b0011, 4'b0000, -1, -1, 16'd3, 1'b0}); // flush
    vecs.push_back('{1'b1, 1'b0, 4'b0011, 4'b0011,  0,  1, 16'd3, 1'b0}); // ptr 3 kept: 0,1
    vecs.push_back('{1'b1, 1'b1, 4'b1111, 4'b0000, -1, -1, 16'd3, 1'b0}); // flush stops counting
    vecs.push_back('{1'b1, 1'b0, 4'b1111, 4'b1100,  2,  3, 16'd4, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'b0010, 4'b0010,  1, -1, 16'd4, 1'b0}); // ptr -> 2, lanes busy
    vecs.push_back('{1'b0, 1'b0, 4'b1111, 4'b0000, -1, -1, 16'd0, 1'b0}); // reset mid-stream
    vecs.push_back('{1'b1, 1'b0, 4'b1111, 4'b0011,  0,  1, 16'd1, 1'b0}); // ptr back at 0
    vecs.push_back('{1'b1, 1'b0, 4'b1111, 4'b1100,  2,  3, 16'd2, 1'b0}); // units held through reset

    pay_idx[FU_FXU0]   = 4'h5; pay_val[FU_FXU0]   = 16'h00AA;
    pay_idx[FU_FXU1]   = 4'h6; pay_val[FU_FXU1]   = 16'h1111;
    pay_idx[FU_LSU]    = 4'h7; pay_val[FU_LSU]    = 16'h2222;
    pay_idx[FU_BRANCH] = 4'h8; pay_val[FU_BRANCH] = 16'h3333;

    // Initial reset with idle inputs, then check the cleared state.
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    drive_payloads();
    repeat (2) @(negedge clk);
    check("reset_cdb_valid", 32'(cdb_valid), 32'h0);
    check("reset_cdb_idx", 32'(cdb_idx), 32'h0);
    check("reset_cdb_value", 32'(cdb_value), 32'h0);
    check("reset_conflict_cnt", 32'(conflict_cnt), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (i > 0) @(negedge clk);
      compare_lanes(i - 1);

      if (v.p2_9) begin
        pay_idx[FU_LSU] = 4'h9;
        pay_val[FU_LSU] = 16'h0999;
      end
      rst_n     = v.rst_n;
      flush     = v.flush;
      req_valid = v.valid;
      drive_payloads();
      #1;
      check($sformatf("req_ready[%0d]", i), 32'(req_ready), 32'(v.ready));

      srcs[0] = v.src0;
      srcs[1] = v.src1;
      e.v    = '0;
      e.idx  = '0;
      e.val  = '0;
      e.cnt  = v.cnt;
      e.zero = ~v.rst_n;
      for (int k = 0; k < NB; k++) begin
        if (srcs[k] >= 0) begin
          e.v[k]            = 1'b1;
          e.idx[k*IW +: IW] = pay_idx[srcs[k]];
          e.val[k*DW +: DW] = pay_val[srcs[k]];
        end
      end
      sb.push_back(e);

      // A unit that transferred this cycle presents a fresh result next time.
      for (int u = 0; u < NR; u++) begin
        if (v.ready[u]) begin
          pay_idx[u] = IW'($urandom);
          pay_val[u] = DW'($urandom);
        end
      end
    end

    @(negedge clk);
    compare_lanes(vecs.size() - 1);

    // Lanes must drop once no one requests.
    req_valid = '0;
    @(negedge clk);
    check("idle_cdb_valid", 32'(cdb_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_cdb_arbiter
